// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment loopback receiver: segment patterns (gfedcba, active-high),
// the hex lookup table and the receiver state encoding.
package seven_seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h39;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;

   // Entry i is the pattern shown for hex digit i.
   localparam logic [15:0][6:0] SEG_TABLE = {
      SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
      SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
   };

   typedef enum logic [1:0] {
      SYNC_WAIT = 2'd0,
      HI_NEXT   = 2'd1,
      LO_NEXT   = 2'd2
   } rx_state_e;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational reverse lookup of one segment pattern to its hex digit, with legality and blank flags.
module seven_seg_decode
   import seven_seg_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] hex,
   output logic       legal,
   output logic       blank
);

   always_comb begin
      hex   = 4'h0;
      legal = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (pattern == SEG_TABLE[i]) begin
            hex   = 4'(i);
            legal = 1'b1;
         end
      end
   end

   assign blank = (pattern == SEG_BLANK);

endmodule

// File: rtl/seven_seg_rx.sv
// Loopback receiver for the multiplexed seven-segment link: rebuilds {upper,lower} digit pairs from
// strobed samples, decodes them, and polices strobe spacing.
module seven_seg_rx
   import seven_seg_pkg::*;
#(
   parameter int FREQ  = 1000,
   parameter int CBITS = 10,
   parameter int SLACK = 16
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  segment,
   input  logic        sig,
   output logic        pair_valid,
   output logic [13:0] both7seg_o,
   output logic [3:0]  hi_hex,
   output logic [3:0]  lo_hex,
   output logic        hi_blank,
   output logic        lo_blank,
   output logic        bad_pat,
   output logic        sync_lost,
   output logic        early_err,
   output logic        locked,
   output logic [7:0]  err_cnt
);

   localparam int GW = CBITS + 1;
   localparam logic [GW-1:0] LATE_LIM  = GW'(FREQ + 1 + SLACK);
   // gap_cnt+1 < FREQ+1-SLACK rewritten as gap_cnt < FREQ-SLACK to avoid a widened adder.
   localparam logic [GW-1:0] EARLY_LIM = GW'(FREQ - SLACK);

   rx_state_e     state;
   logic [GW-1:0] gap_cnt;
   logic [6:0]    cap_hi;
   logic [6:0]    cap_lo;
   logic          hi_fresh;
   logic          lo_fresh;

   logic [3:0] dec_hi_hex, dec_lo_hex;
   logic       dec_hi_legal, dec_lo_legal, dec_hi_blank, dec_lo_blank;

   seven_seg_decode u_dec_hi (
      .pattern (cap_hi),
      .hex     (dec_hi_hex),
      .legal   (dec_hi_legal),
      .blank   (dec_hi_blank)
   );

   seven_seg_decode u_dec_lo (
      .pattern (cap_lo),
      .hex     (dec_lo_hex),
      .legal   (dec_lo_legal),
      .blank   (dec_lo_blank)
   );

   logic checking, timeout, too_early, bad_next, err_any;

   // Timeout has priority, so a strobe arriving on the timeout cycle is ignored.
   assign checking  = (state != SYNC_WAIT);
   assign timeout   = checking && (gap_cnt >= LATE_LIM);
   assign too_early = checking && sig && !timeout && (gap_cnt < EARLY_LIM);
   assign bad_next  = (hi_fresh && !dec_hi_legal && !dec_hi_blank) ||
                      (lo_fresh && !dec_lo_legal && !dec_lo_blank);
   assign err_any   = bad_next || timeout || too_early;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= SYNC_WAIT;
         gap_cnt    <= '0;
         cap_hi     <= '0;
         cap_lo     <= '0;
         hi_fresh   <= 1'b0;
         lo_fresh   <= 1'b0;
         pair_valid <= 1'b0;
         both7seg_o <= '0;
         hi_hex     <= '0;
         lo_hex     <= '0;
         hi_blank   <= 1'b0;
         lo_blank   <= 1'b0;
         bad_pat    <= 1'b0;
         sync_lost  <= 1'b0;
         early_err  <= 1'b0;
         locked     <= 1'b0;
         err_cnt    <= '0;
      end else begin
         if (sig)
            gap_cnt <= '0;
         else if (gap_cnt != '1)
            gap_cnt <= gap_cnt + GW'(1);

         hi_fresh   <= 1'b0;
         lo_fresh   <= 1'b0;
         pair_valid <= lo_fresh;
         bad_pat    <= bad_next;
         sync_lost  <= timeout;
         early_err  <= too_early;

         if (err_any && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;

         // Outputs refresh one cycle after the lower capture, from the registered pair.
         if (lo_fresh) begin
            both7seg_o <= {cap_hi, cap_lo};
            hi_hex     <= dec_hi_hex;
            lo_hex     <= dec_lo_hex;
            hi_blank   <= dec_hi_blank;
            lo_blank   <= dec_lo_blank;
         end

         unique case (state)
            SYNC_WAIT: begin
               if (sig) begin
                  cap_hi   <= segment;
                  hi_fresh <= 1'b1;
                  state    <= LO_NEXT;
                  locked   <= 1'b1;
               end
            end
            HI_NEXT, LO_NEXT: begin
               if (timeout || too_early) begin
                  cap_hi <= '0;
                  state  <= SYNC_WAIT;
                  locked <= 1'b0;
               end else if (sig) begin
                  if (state == HI_NEXT) begin
                     cap_hi   <= segment;
                     hi_fresh <= 1'b1;
                     state    <= LO_NEXT;
                  end else begin
                     cap_lo   <= segment;
                     lo_fresh <= 1'b1;
                     state    <= HI_NEXT;
                  end
               end
            end
            default: begin
               state  <= SYNC_WAIT;
               locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seven_seg_rx.sv
// Scoreboard bench for seven_seg_rx at FREQ=20, SLACK=2 (nominal strobe period 21 cycles).
module tb_seven_seg_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  segment;
   logic        sig;
   logic        pair_valid;
   logic [13:0] both7seg_o;
   logic [3:0]  hi_hex, lo_hex;
   logic        hi_blank, lo_blank, bad_pat, sync_lost, early_err, locked;
   logic [7:0]  err_cnt;

   seven_seg_rx #(.FREQ(20), .CBITS(5), .SLACK(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .segment    (segment),
      .sig        (sig),
      .pair_valid (pair_valid),
      .both7seg_o (both7seg_o),
      .hi_hex     (hi_hex),
      .lo_hex     (lo_hex),
      .hi_blank   (hi_blank),
      .lo_blank   (lo_blank),
      .bad_pat    (bad_pat),
      .sync_lost  (sync_lost),
      .early_err  (early_err),
      .locked     (locked),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_sig = 0;

   // Packed pair view: {both7seg_o, hi_hex, lo_hex, hi_blank, lo_blank}
   logic [23:0] exp_pairs[$];
   // Error pulse view: {bad_pat, sync_lost, early_err}
   logic [2:0]  exp_errs[$];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [6:0] seg, input int period);
      repeat (period - 1) @(posedge clk);
      #1;
      segment = seg;
      sig     = 1'b1;
      @(posedge clk);
      #1;
      sig = 1'b0;
   endtask

   task automatic expectPair(input logic [6:0] up, input logic [6:0] lo, input logic [3:0] hh,
                             input logic [3:0] lh, input logic hb, input logic lb);
      exp_pairs.push_back({up, lo, hh, lh, hb, lb});
   endtask

   always @(posedge clk) begin
      cyc++;
      if (sig) last_sig = cyc;
   end

   // Monitor: compares whatever the DUT presents against the scoreboard queues.
   always @(negedge clk) begin
      if (!rst) begin
         if (pair_valid) begin
            if (exp_pairs.size() == 0)
               checkOutput("unexpected_pair", {both7seg_o, hi_hex, lo_hex, hi_blank, lo_blank}, 64'h0);
            else
               checkOutput("pair", {both7seg_o, hi_hex, lo_hex, hi_blank, lo_blank}, exp_pairs.pop_front());
         end
         if (bad_pat || sync_lost || early_err) begin
            if (exp_errs.size() == 0)
               checkOutput("unexpected_err", {bad_pat, sync_lost, early_err}, 64'h0);
            else
               checkOutput("err_kind", {bad_pat, sync_lost, early_err}, exp_errs.pop_front());
         end
         if (sync_lost) begin
            checks++;
            if ((cyc - last_sig) < 23 || (cyc - last_sig) > 24) begin
               failures++;
               $display("[TB] FAIL sync_lost_delay: got %0d cycles, expected 23..24", cyc - last_sig);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; sig = 1'b0; segment = 7'h00;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_outputs", {pair_valid, both7seg_o, hi_hex, lo_hex, hi_blank, lo_blank,
                                    bad_pat, sync_lost, early_err, locked, err_cnt}, 64'h0);
      rst = 1'b0;

      // 1: basic pair "12"
      applyStimulus(7'h06, 5);
      expectPair(7'h06, 7'h5B, 4'h1, 4'h2, 1'b0, 1'b0);
      applyStimulus(7'h5B, 21);
      checkOutput("locked_after_pair", locked, 1'b1);

      // 2: "8" over a blank lower digit
      applyStimulus(7'h7F, 21);
      expectPair(7'h7F, 7'h00, 4'h8, 4'h0, 1'b0, 1'b1);
      applyStimulus(7'h00, 21);
      @(posedge clk); #1;
      checkOutput("err_cnt_blank", err_cnt, 8'd0);

      // 3: illegal upper still completes the pair
      exp_errs.push_back(3'b100);
      applyStimulus(7'h01, 21);
      expectPair(7'h01, 7'h3F, 4'h0, 4'h0, 1'b0, 1'b0);
      applyStimulus(7'h3F, 21);
      checkOutput("err_cnt_bad", err_cnt, 8'd1);

      // 4: drop the lower strobe
      applyStimulus(7'h66, 21);
      exp_errs.push_back(3'b010);
      repeat (30) @(posedge clk); #1;
      checkOutput("locked_after_loss", locked, 1'b0);
      applyStimulus(7'h6D, 5);
      expectPair(7'h6D, 7'h7D, 4'h5, 4'h6, 1'b0, 1'b0);
      applyStimulus(7'h7D, 21);
      checkOutput("err_cnt_loss", err_cnt, 8'd2);

      // 5: early strobe, then recovery and tolerance edges
      applyStimulus(7'h07, 21);
      exp_errs.push_back(3'b001);
      applyStimulus(7'h77, 10);
      @(posedge clk); #1;
      checkOutput("locked_after_early", locked, 1'b0);
      applyStimulus(7'h77, 10);
      expectPair(7'h77, 7'h7C, 4'hA, 4'hB, 1'b0, 1'b0);
      applyStimulus(7'h7C, 21);
      applyStimulus(7'h39, 23);
      expectPair(7'h39, 7'h5E, 4'hC, 4'hD, 1'b0, 1'b0);
      applyStimulus(7'h5E, 19);
      applyStimulus(7'h79, 21);
      exp_errs.push_back(3'b001);
      applyStimulus(7'h71, 18);
      checkOutput("err_cnt_early", err_cnt, 8'd4);

      // Illegal upper followed immediately by a second strobe: two errors in one cycle count once
      applyStimulus(7'h01, 5);
      exp_errs.push_back(3'b101);
      applyStimulus(7'h06, 1);
      @(posedge clk); #1;
      checkOutput("err_cnt_simul", err_cnt, 8'd5);

      // 6: reset between upper and lower
      applyStimulus(7'h06, 5);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("reset_midpair", {pair_valid, both7seg_o, hi_hex, lo_hex, hi_blank, lo_blank,
                                    bad_pat, sync_lost, early_err, locked, err_cnt}, 64'h0);
      rst = 1'b0;

      // Held strobe: every second sampled edge is early, 300 errors total
      for (int i = 0; i < 300; i++) exp_errs.push_back(3'b001);
      sig = 1'b1; segment = 7'h06;
      repeat (600) @(posedge clk);
      #1 sig = 1'b0;
      repeat (3) @(posedge clk); #1;
      checkOutput("err_cnt_saturate", err_cnt, 8'hFF);

      repeat (5) @(posedge clk); #1;
      checkOutput("pairs_left", exp_pairs.size(), 0);
      checkOutput("errs_left", exp_errs.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
